serial_adder: RTL and testbench

Bit-serial W-bit adder that wraps the team's single-bit full adder cell `fa` with operand shift registers, a carry flip-flop and a control FSM. The block accepts two parallel operands plus carry-in on a start strobe and streams one bit pair per clock, LSB first, through `fa`. It then presents the parallel sum and carry-out with a one-cycle done pulse. It sits directly upstream of `fa`, feeding it, and is the area-minimal adder used where throughput is not critical.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/fa.sv | 13 +
 rtl/serial_adder.sv | 97 +++++++++
 tb/tb_serial_adder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM encoding and width default for serial_adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        SA_IDLE  = 2'd0,
        SA_SHIFT = 2'd1,
        SA_DONE  = 2'd2
    } sa_state_e;

    localparam int SA_W_DEFAULT = 8;

endpackage

// File: rtl/fa.sv
// rtl/fa.sv - single-bit full adder cell
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial W-bit adder around fa; optional ovf via SERIAL_ADDER_OVF_EN
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int W = SA_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam logic [1:0] IDLE  = SA_IDLE;
    localparam logic [1:0] SHIFT = SA_SHIFT;
    localparam logic [1:0] DONE  = SA_DONE;

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [1:0]    state;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  s_sr;
    logic          carry_ff;
    logic [CW-1:0] cnt;
    logic          fa_s;
    logic          fa_co;

    fa u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry_ff),
        .s  (fa_s),
        .co (fa_co)
    );

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            s_sr     <= '0;
            carry_ff <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        carry_ff <= cin;
                        cnt      <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    s_sr     <= {fa_s, s_sr[W-1:1]};
                    carry_ff <= fa_co;
                    a_sr     <= {1'b0, a_sr[W-1:1]};
                    b_sr     <= {1'b0, b_sr[W-1:1]};
                    cnt      <= cnt + 1'b1;
                    // Final bit: publish the result including the bit being computed now
                    if (cnt == LAST) begin
                        sum   <= {fa_s, s_sr[W-1:1]};
                        cout  <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= carry_ff ^ fa_co;
`endif
                        cnt   <= '0;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (ovf checked when SERIAL_ADDER_OVF_EN)
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] last_sum  = '0;
    logic         last_cout = 1'b0;

    serial_adder #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                           input bit scramble, input bit poke, input string tag);
        int full;
        int sgn;
        int lat;
        int extra_done;
        bit seen;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
        full     = int'(ta) + int'(tb) + int'(tc);
        exp_sum  = full[W-1:0];
        exp_cout = full[W];
        sgn      = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
        exp_ovf  = (sgn > 127) || (sgn < -128);

        a = ta; b = tb; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        seen = 0;
        for (int i = 1; i <= W + 3 && !seen; i++) begin
            if (i <= W) begin
                chk({tag, "_busy"}, busy, 1'b1);
                chk({tag, "_hold"}, sum, last_sum);
            end
            if (scramble) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            start = poke && (i == 3);
            if (poke && i == 3) begin
                a = '1; b = '1;
            end
            tick();
            start = 1'b0;
            if (done) begin
                seen = 1;
                lat = i;
            end
        end
        chk({tag, "_latency"}, lat, W);
        chk({tag, "_sum"}, sum, exp_sum);
        chk({tag, "_cout"}, cout, exp_cout);
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"}, ovf, exp_ovf);
`else
        if (exp_ovf) begin end
`endif
        last_sum  = exp_sum;
        last_cout = exp_cout;
        if (poke) begin
            a = '1; b = '1; start = 1'b1;
        end
        tick();
        start = 1'b0;
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_idle_busy"}, busy, 1'b0);
        if (poke) begin
            extra_done = 0;
            for (int j = 0; j < W + 2; j++) begin
                tick();
                if (done || busy) extra_done++;
            end
            chk({tag, "_no_queued"}, extra_done, 0);
            chk({tag, "_sum_kept"}, sum, exp_sum);
        end
    endtask

    initial begin
        int nd;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", ovf, 1'b0);
`endif

        run_add(8'h5A, 8'h3C, 1'b0, 0, 0, "basic");
        run_add(8'h80, 8'h80, 1'b1, 0, 0, "b2b");
        run_add(8'hFF, 8'h01, 1'b0, 0, 0, "wrap0");
        run_add(8'h7F, 8'h00, 1'b1, 0, 0, "wrap80");
        run_add(8'h10, 8'h20, 1'b0, 0, 1, "busy_start");

        // Abort in the 4th busy cycle
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("abort_ovf", ovf, 1'b0);
`endif
        last_sum = '0; last_cout = 1'b0;
        nd = 0;
        for (int j = 0; j < W + 2; j++) begin
            tick();
            if (done) nd++;
        end
        chk("abort_no_done", nd, 0);

        // start and rst together must land in IDLE
        start = 1'b1; rst = 1'b1; a = 8'h33; b = 8'h44;
        tick();
        start = 1'b0; rst = 1'b0;
        chk("rst_start_busy", busy, 1'b0);
        tick();
        chk("rst_start_idle", busy, 1'b0);

        run_add(8'h01, 8'h01, 1'b0, 0, 0, "after_abort");
        run_add(8'hC3, 8'h5E, 1'b1, 1, 0, "stable");

        for (int k = 0; k < 20; k++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom), 1, 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
